// File: rtl/row_regs_loader.sv
// row_regs_loader
// Fetches three feature-map rows per group from the input buffer into a
// staging area, then copies them into the row registers of the shift-register
// stage and pulses shift_start. Fetching group g+1 overlaps the consumer's
// work on group g; a group is handed over only once the consumer is free.
module row_regs_loader #(
   parameter int shift_regs_num = 70,
   parameter int ADDR_W         = 16,
   parameter int WORD_PIX       = 8,
   parameter int WORDS_PER_ROW  = 9
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  s,
   input  logic                        job_start,
   input  logic [ADDR_W-1:0]           row_base,
   input  logic [ADDR_W-1:0]           row_stride,
   input  logic [15:0]                 num_groups,
   output logic                        job_busy,
   output logic                        job_done,
   output logic                        buf_rd_en,
   output logic [ADDR_W-1:0]           buf_rd_addr,
   input  logic [WORD_PIX*8-1:0]       buf_rd_data,
   output logic [shift_regs_num*8-1:0] row_regs_1,
   output logic [shift_regs_num*8-1:0] row_regs_2,
   output logic [shift_regs_num*8-1:0] row_regs_3,
   output logic                        shift_start,
   input  logic                        re_fm_end
);

   localparam int ROW_W   = shift_regs_num * 8;
   localparam int WORD_CW = $clog2(WORDS_PER_ROW);
   localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(WORDS_PER_ROW - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, DRAIN, WAIT_CONS, ISSUE, FINISH
   } state_t;

   state_t state_q, state_d;

   // Job parameters and fetch position
   logic [ADDR_W-1:0]  stride_q;
   logic [ADDR_W-1:0]  grp_base_q;   // address of row 0, word 0 of current group
   logic [ADDR_W-1:0]  row_addr_q;   // address of word 0 of the row being read
   logic [15:0]        groups_q;
   logic [15:0]        grp_q;        // index of the group being fetched
   logic [WORD_CW-1:0] word_q;
   logic [1:0]         row_q;

   // Read-return tracking: data arrives one cycle after the strobe
   logic               cap_en_q;
   logic [1:0]         cap_row_q;
   logic [WORD_CW-1:0] cap_word_q;

   logic cons_busy_q;
   logic shift_start_q;
   logic job_done_q;

   // Decoded control
   logic              accept;
   logic              last_read;
   logic              more_groups;
   logic              finish_ok;
   logic [ADDR_W-1:0] grp_step;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (job_start && (num_groups != 16'd0)) state_d = FETCH;
         FETCH:     if (last_read) state_d = DRAIN;
         DRAIN:     state_d = WAIT_CONS;
         WAIT_CONS: if (!cons_busy_q && !shift_start_q) state_d = ISSUE;
         ISSUE:     state_d = more_groups ? FETCH : FINISH;
         FINISH:    if (finish_ok) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FSM outputs and decoded control
   always_comb begin
      accept      = job_start && (state_q == IDLE);
      last_read   = (word_q == LAST_WORD) && (row_q == 2'd2);
      more_groups = (grp_q + 16'd1) != groups_q;
      finish_ok   = cons_busy_q && re_fm_end;
      // Any stride other than 2 advances one row per group
      grp_step    = (s == 4'd2) ? {stride_q[ADDR_W-2:0], 1'b0} : stride_q;
      job_busy    = (state_q != IDLE);
      buf_rd_en   = (state_q == FETCH);
      buf_rd_addr = '0;
      if (state_q == FETCH) buf_rd_addr = row_addr_q + ADDR_W'(word_q);
   end

   // Fetch counters, address generation and job parameter capture
   always_ff @(posedge clk) begin
      if (reset) begin
         stride_q   <= '0;
         grp_base_q <= '0;
         row_addr_q <= '0;
         groups_q   <= '0;
         grp_q      <= '0;
         word_q     <= '0;
         row_q      <= '0;
         cap_en_q   <= 1'b0;
         cap_row_q  <= '0;
         cap_word_q <= '0;
      end else begin
         cap_en_q   <= buf_rd_en;
         cap_row_q  <= row_q;
         cap_word_q <= word_q;
         if (accept) begin
            stride_q   <= row_stride;
            grp_base_q <= row_base;
            row_addr_q <= row_base;
            groups_q   <= num_groups;
            grp_q      <= '0;
            word_q     <= '0;
            row_q      <= '0;
         end
         if (state_q == FETCH) begin
            if (word_q == LAST_WORD) begin
               word_q <= '0;
               if (row_q == 2'd2) begin
                  row_q <= '0;
               end else begin
                  row_q      <= row_q + 2'd1;
                  row_addr_q <= row_addr_q + stride_q;
               end
            end else begin
               word_q <= word_q + WORD_CW'(1);
            end
         end
         if (state_q == ISSUE) begin
            grp_q      <= grp_q + 16'd1;
            grp_base_q <= grp_base_q + grp_step;
            row_addr_q <= grp_base_q + grp_step;
         end
      end
   end

   // Handshake registers: shift_start / job_done pulses and consumer busy flag
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_start_q <= 1'b0;
         job_done_q    <= 1'b0;
         cons_busy_q   <= 1'b0;
      end else begin
         shift_start_q <= (state_q == ISSUE);
         job_done_q    <= (accept && (num_groups == 16'd0)) ||
                          ((state_q == FINISH) && finish_ok);
         // A new hand-over wins over a simultaneous completion
         if (shift_start_q)  cons_busy_q <= 1'b1;
         else if (re_fm_end) cons_busy_q <= 1'b0;
      end
   end

   // One staging row and one output row register per fetched row
   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic [ROW_W-1:0] stage_q;
      logic [ROW_W-1:0] rows_q;

      // Scatter returned bytes into pixel lanes; bytes past the last pixel drop
      always_ff @(posedge clk) begin
         if (reset) begin
            stage_q <= '0;
         end else if (cap_en_q && (cap_row_q == 2'(gi))) begin
            for (int p = 0; p < shift_regs_num; p++) begin
               if (cap_word_q == WORD_CW'(p / WORD_PIX))
                  stage_q[p*8 +: 8] <= buf_rd_data[(p % WORD_PIX)*8 +: 8];
            end
         end
      end

      // Row registers change only on hand-over, so the consumer sees stable data
      always_ff @(posedge clk) begin
         if (reset)                  rows_q <= '0;
         else if (state_q == ISSUE)  rows_q <= stage_q;
      end
   end

   assign row_regs_1  = g_row[0].rows_q;
   assign row_regs_2  = g_row[1].rows_q;
   assign row_regs_3  = g_row[2].rows_q;
   assign shift_start = shift_start_q;
   assign job_done    = job_done_q;

endmodule

// File: tb/tb_row_regs_loader.sv
// Testbench for row_regs_loader: buffer model, consumer model, scoreboard
// queues filled from the addressing/packing rules, monitor popping on
// every read strobe, shift_start and job_done.
module tb_row_regs_loader;

   localparam int NPIX = 70;
   localparam int RW   = NPIX * 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    s = 4'd1;
   logic          job_start = 1'b0;
   logic [15:0]   row_base = '0;
   logic [15:0]   row_stride = '0;
   logic [15:0]   num_groups = '0;
   logic          job_busy, job_done, buf_rd_en, shift_start;
   logic [15:0]   buf_rd_addr;
   logic [63:0]   buf_rd_data = '0;
   logic [RW-1:0] row_regs_1, row_regs_2, row_regs_3;
   logic          re_fm_end = 1'b0;

   always #5 clk = ~clk;

   row_regs_loader dut (
      .clk(clk), .reset(reset), .s(s), .job_start(job_start),
      .row_base(row_base), .row_stride(row_stride), .num_groups(num_groups),
      .job_busy(job_busy), .job_done(job_done),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .row_regs_1(row_regs_1), .row_regs_2(row_regs_2), .row_regs_3(row_regs_3),
      .shift_start(shift_start), .re_fm_end(re_fm_end)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   logic [7:0] salt = 8'd0;

   // Scoreboard queues
   logic [15:0]   exp_addr_q[$];
   logic [RW-1:0] exp_r1_q[$], exp_r2_q[$], exp_r3_q[$];
   int            exp_done_q[$];

   // Monitor / consumer state
   bit      mon_off = 1'b1;
   bit      busy_m = 1'b0;
   bit      stray_en = 1'b0;
   bit      prev_shift = 1'b0;
   bit      have_rows = 1'b0;
   int      cd = 0;
   int      cons_delay = 0;
   int      shifts_job = 0;
   int      reads_job = 0;
   int      dones = 0;
   int      first_shift_cyc = 0;
   logic [RW-1:0] last_r1, last_r2, last_r3;

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer word content: byte b of word a is a*8+b+salt
   function automatic logic [63:0] mem_word(input logic [15:0] a);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(int'(a) * 8 + b + int'(salt));
      return w;
   endfunction

   always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem_word(buf_rd_addr);

   // Expected row r of group g straight from the address and packing rules
   function automatic logic [RW-1:0] exp_row(input logic [15:0] base, input logic [15:0] stride,
                                             input int g, input int r, input int seff);
      logic [RW-1:0] row;
      logic [15:0]   a;
      for (int i = 0; i < NPIX; i++) begin
         a = 16'(int'(base) + (g * seff + r) * int'(stride) + i / 8);
         row[i*8 +: 8] = 8'(int'(a) * 8 + (i % 8) + int'(salt));
      end
      return row;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: got event with no expectation (or none when one was required)", nm);
   endtask

   // Monitor: pops expectations on DUT events, and plays the consumer
   always @(negedge clk) begin
      logic [RW-1:0] e1, e2, e3;
      if (mon_off) begin
         busy_m = 1'b0; cd = 0; re_fm_end = 1'b0; prev_shift = 1'b0;
      end else begin
         if (buf_rd_en) begin
            reads_job++;
            if (exp_addr_q.size() == 0) miss("rd_unexpected");
            else chk("rd_addr", buf_rd_addr, exp_addr_q.pop_front());
         end
         if (shift_start) begin
            chk("shift_while_busy", busy_m, 0);
            chk("shift_back_to_back", prev_shift, 0);
            chk("reads_before_shift", reads_job >= 27 * (shifts_job + 1), 1);
            if (exp_r1_q.size() == 0) begin
               miss("shift_unexpected");
            end else begin
               e1 = exp_r1_q.pop_front(); e2 = exp_r2_q.pop_front(); e3 = exp_r3_q.pop_front();
               chk_row("row_regs_1", row_regs_1, e1);
               chk_row("row_regs_2", row_regs_2, e2);
               chk_row("row_regs_3", row_regs_3, e3);
            end
            if (shifts_job == 0) first_shift_cyc = cyc;
            shifts_job++;
            last_r1 = row_regs_1; last_r2 = row_regs_2; last_r3 = row_regs_3;
            have_rows = 1'b1;
         end else if (have_rows) begin
            chk("row_regs_stable", (row_regs_1 === last_r1) && (row_regs_2 === last_r2)
                                   && (row_regs_3 === last_r3), 1);
         end
         prev_shift = shift_start;
         if (job_done) begin
            if (exp_done_q.size() == 0) miss("done_unexpected");
            else begin
               void'(exp_done_q.pop_front());
               n_vec++;
               dones++;
            end
         end
         re_fm_end = 1'b0;
         if (busy_m) begin
            if (cd == 0) begin re_fm_end = 1'b1; busy_m = 1'b0; end
            else cd--;
         end else if (stray_en && ($urandom_range(0, 15) == 0)) begin
            re_fm_end = 1'b1;
         end
         if (shift_start) begin busy_m = 1'b1; cd = cons_delay; end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_job_busy"},    job_busy, 0);
      chk({nm, "_job_done"},    job_done, 0);
      chk({nm, "_buf_rd_en"},   buf_rd_en, 0);
      chk({nm, "_buf_rd_addr"}, buf_rd_addr, 0);
      chk({nm, "_shift_start"}, shift_start, 0);
      chk({nm, "_row_regs"}, (row_regs_1 == '0) && (row_regs_2 == '0) && (row_regs_3 == '0), 1);
   endtask

   task automatic push_job(input logic [15:0] base, input logic [15:0] stride,
                           input logic [15:0] ng, input logic [3:0] sv);
      int seff;
      seff = (sv == 4'd2) ? 2 : 1;
      for (int g = 0; g < int'(ng); g++) begin
         for (int r = 0; r < 3; r++)
            for (int w = 0; w < 9; w++)
               exp_addr_q.push_back(16'(int'(base) + (g * seff + r) * int'(stride) + w));
         exp_r1_q.push_back(exp_row(base, stride, g, 0, seff));
         exp_r2_q.push_back(exp_row(base, stride, g, 1, seff));
         exp_r3_q.push_back(exp_row(base, stride, g, 2, seff));
      end
   endtask

   task automatic run_job(input logic [15:0] base, input logic [15:0] stride, input logic [15:0] ng,
                          input logic [3:0] sv, input int delay, input int glitch_at,
                          input logic [7:0] slt);
      int  start, d0;
      bit  done;
      @(negedge clk);
      salt = slt; cons_delay = delay; s = sv;
      row_base = base; row_stride = stride; num_groups = ng; job_start = 1'b1;
      start = cyc; d0 = dones; shifts_job = 0; reads_job = 0;
      push_job(base, stride, ng, sv);
      exp_done_q.push_back(1);
      done = 1'b0;
      for (int k = 1; k < 20000 && !done; k++) begin
         @(negedge clk);
         if (k == 1 && ng == 16'd0) chk("empty_job_done_latency", job_done, 1);
         if (k == glitch_at) begin
            job_start = 1'b1; row_base = ~base; row_stride = stride + 16'd3; num_groups = ng + 16'd5;
         end else begin
            job_start = 1'b0;
         end
         if (dones != d0) done = 1'b1;
      end
      job_start = 1'b0;
      if (!done) miss("job_done_timeout");
      chk("reads_left", exp_addr_q.size(), 0);
      chk("groups_left", exp_r1_q.size(), 0);
      chk("shift_count", shifts_job, ng);
      if (ng != 16'd0) chk("first_shift_latency", first_shift_cyc - start, 31);
      $display("job base=%h stride=%h groups=%0d s=%0d delay=%0d reads=%0d shifts=%0d",
               base, stride, ng, sv, delay, reads_job, shifts_job);
   endtask

   // Reset during FETCH aborts the job without job_done
   task automatic abort_job();
      @(negedge clk);
      salt = 8'h5a; cons_delay = 2; s = 4'd1;
      row_base = 16'h0200; row_stride = 16'd30; num_groups = 16'd2; job_start = 1'b1;
      shifts_job = 0; reads_job = 0;
      push_job(16'h0200, 16'd30, 16'd2, 4'd1);
      exp_done_q.push_back(1);
      @(negedge clk);
      job_start = 1'b0;
      repeat (9) @(negedge clk);
      chk("fetch_active_before_reset", buf_rd_en, 1);
      mon_off = 1'b1; reset = 1'b1;
      @(negedge clk);
      chk_all_zero("after_abort");
      exp_addr_q.delete(); exp_r1_q.delete(); exp_r2_q.delete(); exp_r3_q.delete();
      exp_done_q.delete();
      have_rows = 1'b0;
      @(negedge clk);
      reset = 1'b0; mon_off = 1'b0;
      $display("abort during fetch, outputs cleared");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0; mon_off = 1'b0;
      @(negedge clk);

      run_job(16'd0, 16'd16, 16'd1, 4'd1, 5, -1, 8'h00);
      chk("row2_pixel0", row_regs_2[7:0], 8'h80);
      run_job(16'd0, 16'd16, 16'd3, 4'd2, 3, -1, 8'h11);
      run_job(16'h0100, 16'd40, 16'd2, 4'd1, 60, -1, 8'h22);
      run_job(16'd5, 16'd7, 16'd0, 4'd1, 0, -1, 8'h33);
      abort_job();
      run_job(16'h0020, 16'd12, 16'd1, 4'd1, 2, -1, 8'h44);
      run_job(16'h0040, 16'd20, 16'd2, 4'd1, 4, 5, 8'h66);

      stray_en = 1'b1;
      for (int j = 0; j < 6; j++)
         run_job(16'($urandom), 16'($urandom), 16'($urandom_range(1, 4)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 70), -1, 8'($urandom));
      stray_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
